// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared op encoding and width helpers for the program counter
package pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_JMP,
        OP_REL,
        OP_CALL,
        OP_RET
    } pc_op_e;

    // Stack-pointer width: must hold the values 0..depth inclusive.
    function automatic int sp_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic pc_op_e encode_op(
        input logic stall,
        input logic inc_en,
        input logic jmp_en,
        input logic rel_en,
        input logic call_en,
        input logic ret_en
    );
        if (stall)        return OP_HOLD;
        else if (inc_en)  return OP_INC;
        else if (jmp_en)  return OP_JMP;
        else if (rel_en)  return OP_REL;
        else if (call_en) return OP_CALL;
        else if (ret_en)  return OP_RET;
        else              return OP_HOLD;
    endfunction

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - LIFO of return addresses; push-when-full and pop-when-empty are dropped
module return_stack
    import pc_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             top_data,
    output logic [sp_w(DEPTH)-1:0]   sp,
    output logic                     full,
    output logic                     empty
);

    localparam int SP_W  = sp_w(DEPTH);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]    stack_q [DEPTH];
    logic [SP_W-1:0] sp_q;
    logic [SP_W-1:0] sp_m1;

    assign sp_m1    = sp_q - SP_W'(1);
    assign full     = (sp_q == SP_W'(DEPTH));
    assign empty    = (sp_q == '0);
    assign sp       = sp_q;
    assign top_data = empty ? '0 : stack_q[sp_m1[IDX_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push && !full) begin
            stack_q[sp_q[IDX_W-1:0]] <= push_data;
            sp_q                     <= sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            // Popped entry is left in place; only the pointer moves.
            sp_q <= sp_m1;
        end
    end

endmodule

// File: rtl/program_counter_rs.sv
// rtl/program_counter_rs.sv - program counter with nested call/return stack and sticky stack errors
module program_counter_rs
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RET_OFFSET  = 1,
    parameter int RESET_ADDR  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          inc_en,
    input  logic                          jmp_en,
    input  logic                          rel_en,
    input  logic                          call_en,
    input  logic                          ret_en,
    input  logic                          clr_err,
    input  logic [ADDR_W-1:0]             ld_addr,
    input  logic [ADDR_W-1:0]             offset,
    output logic [ADDR_W-1:0]             count,
    output logic [sp_w(STACK_DEPTH)-1:0]  sp,
    output logic                          stack_full,
    output logic                          stack_empty,
    output logic                          overflow_err,
    output logic                          underflow_err
);

    pc_op_e            op;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] top_data;
    logic              push;
    logic              pop;
    logic              ovf_set;
    logic              unf_set;
    logic              ovf_q;
    logic              unf_q;

    assign op      = encode_op(stall, inc_en, jmp_en, rel_en, call_en, ret_en);
    assign push    = (op == OP_CALL) && !stack_full;
    assign pop     = (op == OP_RET)  && !stack_empty;
    assign ovf_set = (op == OP_CALL) &&  stack_full;
    assign unf_set = (op == OP_RET)  &&  stack_empty;

    return_stack #(
        .W     (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (count_q + ADDR_W'(RET_OFFSET)),
        .top_data  (top_data),
        .sp        (sp),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= ADDR_W'(RESET_ADDR);
        end else begin
            case (op)
                OP_INC:  count_q <= count_q + ADDR_W'(1);
                OP_JMP:  count_q <= ld_addr;
                OP_REL:  count_q <= count_q + offset;
                OP_CALL: if (push) count_q <= ld_addr;
                OP_RET:  if (pop)  count_q <= top_data;
                default: count_q <= count_q;
            endcase
        end
    end

    // Set wins over clear; a stalled cycle leaves the flags untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= ovf_set | (ovf_q & ~clr_err);
            unf_q <= unf_set | (unf_q & ~clr_err);
        end
    end

    assign count         = count_q;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_program_counter_rs.sv
// tb/tb_program_counter_rs.sv - vector table, reset corner case and randomized model check
module tb_program_counter_rs;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int SP_W   = $clog2(DEPTH + 1);

    localparam int S = 64, I = 32, J = 16, R = 8, C = 4, T = 2, K = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall, inc_en, jmp_en, rel_en, call_en, ret_en, clr_err;
    logic [ADDR_W-1:0] ld_addr, offset;
    logic [ADDR_W-1:0] count;
    logic [SP_W-1:0]   sp;
    logic              stack_full, stack_empty, overflow_err, underflow_err;

    int n_pass = 0;
    int n_total = 0;

    program_counter_rs #(
        .ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RET_OFFSET(1), .RESET_ADDR(0)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .inc_en(inc_en), .jmp_en(jmp_en),
        .rel_en(rel_en), .call_en(call_en), .ret_en(ret_en), .clr_err(clr_err),
        .ld_addr(ld_addr), .offset(offset), .count(count), .sp(sp),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int en;
        int ld;
        int off;
        int e_count;
        int e_sp;
        int e_ovf;
        int e_unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int en, int ld, int off, int ec, int es, int eo, int eu);
        vec_t v;
        v.en = en; v.ld = ld; v.off = off;
        v.e_count = ec; v.e_sp = es; v.e_ovf = eo; v.e_unf = eu;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input int en, input int ld, input int off);
        stall   = en[6]; inc_en = en[5]; jmp_en = en[4]; rel_en = en[3];
        call_en = en[2]; ret_en = en[1]; clr_err = en[0];
        ld_addr = ADDR_W'(ld); offset = ADDR_W'(off);
    endtask

    task automatic step(input int en, input int ld, input int off);
        drive(en, ld, off);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int ec, input int es, input int eo, input int eu);
        chk({tag, ".count"}, int'(count), ec);
        chk({tag, ".sp"}, int'(sp), es);
        chk({tag, ".full"}, int'(stack_full), int'(es == DEPTH));
        chk({tag, ".empty"}, int'(stack_empty), int'(es == 0));
        chk({tag, ".ovf"}, int'(overflow_err), eo);
        chk({tag, ".unf"}, int'(underflow_err), eu);
    endtask

    // Reference model state
    int m_count;
    int m_stack[$];
    int m_ovf, m_unf;

    task automatic model_step(input int en, input int ld, input int off);
        int ovf_set, unf_set;
        ovf_set = 0; unf_set = 0;
        if (en[6]) return;
        if (en[5])      m_count = (m_count + 1) % 256;
        else if (en[4]) m_count = ld;
        else if (en[3]) m_count = (m_count + off) % 256;
        else if (en[2]) begin
            if (m_stack.size() == DEPTH) ovf_set = 1;
            else begin
                m_stack.push_back((m_count + 1) % 256);
                m_count = ld;
            end
        end else if (en[1]) begin
            if (m_stack.size() == 0) unf_set = 1;
            else m_count = m_stack.pop_back();
        end
        m_ovf = ovf_set | (m_ovf & ~en[0]);
        m_unf = unf_set | (m_unf & ~en[0]);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0);

        vecs.push_back(mk(I,        0,    0,    'h01, 0, 0, 0));
        vecs.push_back(mk(I,        0,    0,    'h02, 0, 0, 0));
        vecs.push_back(mk(I,        0,    0,    'h03, 0, 0, 0));
        vecs.push_back(mk(J,        'hFF, 0,    'hFF, 0, 0, 0));
        vecs.push_back(mk(I,        0,    0,    'h00, 0, 0, 0));
        vecs.push_back(mk(J,        'h10, 0,    'h10, 0, 0, 0));
        vecs.push_back(mk(R,        0,    'hFC, 'h0C, 0, 0, 0));
        vecs.push_back(mk(R,        0,    'h05, 'h11, 0, 0, 0));
        vecs.push_back(mk(R,        0,    'hF0, 'h01, 0, 0, 0));
        vecs.push_back(mk(R,        0,    'hFE, 'hFF, 0, 0, 0));
        vecs.push_back(mk(J,        'h10, 0,    'h10, 0, 0, 0));
        vecs.push_back(mk(C,        'h20, 0,    'h20, 1, 0, 0));
        vecs.push_back(mk(C,        'h30, 0,    'h30, 2, 0, 0));
        vecs.push_back(mk(C,        'h40, 0,    'h40, 3, 0, 0));
        vecs.push_back(mk(C,        'h50, 0,    'h50, 4, 0, 0));
        vecs.push_back(mk(C,        'h60, 0,    'h50, 4, 1, 0));
        vecs.push_back(mk(T,        0,    0,    'h41, 3, 1, 0));
        vecs.push_back(mk(T,        0,    0,    'h31, 2, 1, 0));
        vecs.push_back(mk(T,        0,    0,    'h21, 1, 1, 0));
        vecs.push_back(mk(T,        0,    0,    'h11, 0, 1, 0));
        vecs.push_back(mk(K,        0,    0,    'h11, 0, 0, 0));
        vecs.push_back(mk(T,        0,    0,    'h11, 0, 0, 1));
        vecs.push_back(mk(K,        0,    0,    'h11, 0, 0, 0));
        vecs.push_back(mk(T|K,      0,    0,    'h11, 0, 0, 1));
        vecs.push_back(mk(K,        0,    0,    'h11, 0, 0, 0));
        vecs.push_back(mk(J,        'h05, 0,    'h05, 0, 0, 0));
        vecs.push_back(mk(I|J|C,    'h80, 0,    'h06, 0, 0, 0));
        vecs.push_back(mk(J,        'h05, 0,    'h05, 0, 0, 0));
        vecs.push_back(mk(S|I|J|C,  'h80, 0,    'h05, 0, 0, 0));
        vecs.push_back(mk(T,        0,    0,    'h05, 0, 0, 1));
        vecs.push_back(mk(S|K|T,    0,    0,    'h05, 0, 0, 1));
        vecs.push_back(mk(K,        0,    0,    'h05, 0, 0, 0));
        vecs.push_back(mk(J|C,      'hFF, 0,    'hFF, 0, 0, 0));
        vecs.push_back(mk(C,        'h00, 0,    'h00, 1, 0, 0));
        vecs.push_back(mk(T,        0,    0,    'h00, 0, 0, 0));

        #12;
        rst = 1'b1;
        #1;
        chk_state("reset", 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].ld, vecs[i].off);
            chk_state($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_sp,
                      vecs[i].e_ovf, vecs[i].e_unf);
        end

        step(J, 'h31, 0);
        step(C, 'h40, 0);
        step(C, 'h33, 0);
        chk_state("pre_rst", 'h33, 2, 0, 0);
        drive(C, 'h77, 0);
        rst = 1'b0;
        #2;
        chk_state("async_rst", 0, 0, 0, 0);
        @(posedge clk);
        #3;
        drive(0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_state("post_rst", 0, 0, 0, 0);

        m_count = 0;
        m_stack.delete();
        m_ovf = 0;
        m_unf = 0;
        for (int n = 0; n < 3000; n++) begin
            int en, ld, off;
            en = 0;
            if ($urandom_range(0, 9) == 0) en |= S;
            if ($urandom_range(0, 5) == 0) en |= I;
            if ($urandom_range(0, 5) == 0) en |= J;
            if ($urandom_range(0, 5) == 0) en |= R;
            if ($urandom_range(0, 2) == 0) en |= C;
            if ($urandom_range(0, 2) == 0) en |= T;
            if ($urandom_range(0, 7) == 0) en |= K;
            ld  = int'($urandom_range(0, 255));
            off = int'($urandom_range(0, 255));
            step(en, ld, off);
            model_step(en, ld, off);
            chk_state($sformatf("rnd%0d", n), m_count, m_stack.size(), m_ovf, m_unf);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/program_counter_rs.md
Name: program_counter_rs

Overview:
Parametrised program counter with a multi-level return-address stack (LIFO), replacing the single return register of the first-generation PC. Supports increment, absolute jump, PC-relative branch, nested call and return, plus a pipeline stall. Errors are reported for stack overflow and underflow. Sits between control logic and instruction memory; `count` drives the instruction-memory address.

Parameters:
- ADDR_W, 8: width of the PC, addresses and the stack entries.
- STACK_DEPTH, 4: number of return-address entries (>=1).
- RET_OFFSET, 1: value added to the current count to form the pushed return address.
- RESET_ADDR, 0: count value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall  input  1  freezes PC, stack and error flags this cycle (highest priority).
- inc_en  input  1  count <- count+1.
- jmp_en  input  1  count <- ld_addr (used for jmp and jmpc).
- rel_en  input  1  count <- count + sign-extended offset.
- call_en  input  1  push count+RET_OFFSET, then count <- ld_addr.
- ret_en  input  1  count <- popped return address.
- clr_err  input  1  clears the sticky error flags.
- ld_addr  input  ADDR_W  absolute target.
- offset  input  ADDR_W  two's-complement relative displacement.
- count  output  ADDR_W  current PC (registered).
- sp  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  output  1  sp == STACK_DEPTH.
- stack_empty  output  1  sp == 0.
- overflow_err  output  1  sticky; a call was attempted while full.
- underflow_err  output  1  sticky; a return was attempted while empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - count=RESET_ADDR, sp=0, all stack entries 0, both error flags 0.
  - Reset asserted mid-call or mid-return discards the operation.
- Enables are unregistered and sampled on the rising clk edge. All updates take exactly 1 cycle; `count` reflects the new value after that edge.
- Priority: stall > inc_en > jmp_en > rel_en > call_en > ret_en > hold. Only the highest-priority asserted enable acts; the rest are ignored.
- Arithmetic is modulo 2^ADDR_W:
  - inc from all-ones wraps to 0.
  - A relative branch wraps in either direction.
  - The return address wraps the same way.
- call_en with sp < STACK_DEPTH:
  - stack[sp] <- count_q + RET_OFFSET; sp <- sp+1; count <- ld_addr.
- call_en with sp == STACK_DEPTH:
  - count, stack and sp are unchanged; overflow_err <- 1.
- ret_en with sp > 0:
  - count <- stack[sp-1]; sp <- sp-1. The popped entry need not be cleared.
- ret_en with sp == 0:
  - count and sp are unchanged; underflow_err <- 1.
- Error flags:
  - Set-dominant: if clr_err and a new error occur in the same cycle, the flag ends at 1.
  - clr_err is ignored while stall is high.
  - Setting a flag never alters count.
- stall=1: every register holds, regardless of the other inputs.
- stack_full and stack_empty are combinational decodes of the registered sp.
- No FSM beyond the PC/sp registers; the design is a single-cycle operation decoder.

Decomposition:
- Package pc_pkg holds:
  - enum pc_op_e {OP_HOLD, OP_INC, OP_JMP, OP_REL, OP_CALL, OP_RET};
  - a function that encodes the enables to pc_op_e in the priority order above;
  - a SP_W localparam helper.
- Sub-module return_stack:
  - Parametrised LIFO: push, pop, push_data, top_data, sp, full, empty.
  - Push when full and pop when empty are ignored internally.
  - The top level decodes errors from full/empty.

Test Plan:
- Reset then 3 cycles of inc_en, ADDR_W=8 -> count 0,1,2,3; then force count=0xFF via jmp, inc -> 0x00.
- count=0x10, rel_en with offset=0xFC -> count=0x0C; from 0x0C, offset=0x05 -> 0x11.
- STACK_DEPTH=4: calls from 0x10, 0x20, 0x30, 0x40 to targets 0x20, 0x30, 0x40, 0x50.
  - Result: sp=4, stack_full=1.
  - A 5th call -> count stays 0x50, overflow_err=1.
  - Then 4 rets -> count 0x41, 0x31, 0x21, 0x11.
- sp=0, ret_en -> count unchanged, underflow_err=1; next cycle clr_err -> 0; clr_err together with another empty ret -> flag stays 1.
- inc_en, jmp_en and call_en all asserted together, with ld_addr=0x80 and count=5 -> count=6, sp unchanged; the same with stall=1 -> count=5.
- Mid-sequence (sp=2, count=0x33), assert rst low between edges -> count=RESET_ADDR and sp=0 immediately, without waiting for a clock edge.
